// File: rtl/rsa_pkg.sv
// Shared types for the RSA modular-exponentiation core: FSM states,
// Montgomery operand selects and the accumulator width helper.
package rsa_pkg;

  // Top-level sequencer states. SKIP is only reachable when the core is
  // built with leading-zero skipping.
  typedef enum logic [3:0] {
    IDLE,
    CHECK,
    SKIP,
    TO_MONT,
    INIT_ACC,
    SQR,
    MUL,
    FROM_MONT,
    DONE
  } state_e;

  // Montgomery operand sources. SEL_ACC is the multiplier's own last result,
  // which is the running accumulator A. SEL_R2 feeds the host-supplied
  // R^2 mod n into the domain-conversion steps.
  typedef enum logic [2:0] {
    SEL_M,
    SEL_ONE,
    SEL_ACC,
    SEL_MM,
    SEL_R2
  } sel_e;

  // Two guard bits keep acc + b + n (< 4n) from overflowing.
  localparam int unsigned ACC_GUARD = 2;

  function automatic int unsigned acc_width(input int unsigned k);
    return k + ACC_GUARD;
  endfunction

endpackage

// File: rtl/mont_mul_r2.sv
// Bit-serial radix-2 Montgomery multiplier: p = a*b*2^-K mod n, fully
// reduced. One issue cycle (start), K iterations, one final subtract;
// done pulses for one cycle with p valid, K+2 cycles after start.
// Operands must be < n, n odd.
module mont_mul_r2
  import rsa_pkg::*;
#(
  parameter int K = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic [K-1:0] n,
  output logic         done,
  output logic [K-1:0] p
);

  localparam int AW   = acc_width(K);
  localparam int LOGK = $clog2(K + 1);

  logic [K-1:0]    a_sh;
  logic [K-1:0]    b_r;
  logic [K-1:0]    n_r;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   t_add;
  logic [AW-1:0]   t_red;
  logic [LOGK-1:0] cnt;
  logic            run;
  logic            fin;

  // One iteration: add a_i*b, add n if odd so the low bit clears, halve.
  always_comb begin
    t_add = acc + (a_sh[0] ? AW'(b_r) : '0);
    t_red = t_add + (t_add[0] ? AW'(n_r) : '0);
  end

  // Issue / iterate / final-subtract sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh <= '0;
      b_r  <= '0;
      n_r  <= '0;
      acc  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      fin  <= 1'b0;
      done <= 1'b0;
      p    <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        a_sh <= a;
        b_r  <= b;
        n_r  <= n;
        acc  <= '0;
        cnt  <= '0;
        run  <= 1'b1;
        fin  <= 1'b0;
      end else if (run) begin
        acc  <= t_red >> 1;
        a_sh <= a_sh >> 1;
        cnt  <= cnt + 1'b1;
        if (cnt == LOGK'(K - 1)) begin
          run <= 1'b0;
          fin <= 1'b1;
        end
      end else if (fin) begin
        fin  <= 1'b0;
        done <= 1'b1;
        if (acc >= AW'(n_r)) p <= K'(acc - AW'(n_r));
        else                 p <= K'(acc);
      end
    end
  end

endmodule

// File: rtl/rsa_modexp_core.sv
// RSA modular exponentiation: data_out = data_in^exp_in mod mod_n using
// left-to-right square-and-multiply over a Montgomery multiplier.
// Key material (n, exponent, R^2 mod n) arrives with each request.
// Optional build macro RSA_LZ_SKIP_EN: skip leading-zero exponent bits
// (default off keeps square count independent of the exponent value).
module rsa_modexp_core
  import rsa_pkg::*;
#(
  parameter int K     = 12,
  parameter int EXP_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K-1:0]     data_in,
  input  logic [K-1:0]     mod_n,
  input  logic [EXP_W-1:0] exp_in,
  input  logic [K-1:0]     r2_mod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K-1:0]     data_out,
  output logic             err,
  output logic             busy
);

  localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  state_e           state, nxt;
  logic [K-1:0]     m_r, n_r, r2_r, mm_r;
  logic [EXP_W-1:0] e_r;
  logic [IW-1:0]    idx, idx_start;
  logic             bad;

  logic             start, done;
  logic [K-1:0]     p, op_a, op_b;
  sel_e             sel_a, sel_b;
  logic             load_mm, idx_init, idx_dec, set_ok, set_bad;

`ifdef RSA_LZ_SKIP_EN
  function automatic logic [IW-1:0] msb_pos(input logic [EXP_W-1:0] e);
    msb_pos = '0;
    for (int i = 0; i < EXP_W; i++)
      if (e[i]) msb_pos = IW'(i);
  endfunction
  assign idx_start = msb_pos(e_r);
`else
  assign idx_start = IW'(EXP_W - 1);
`endif

  assign bad      = !n_r[0] || (n_r < K'(3)) || (m_r >= n_r);
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Operand muxes; sampled by the multiplier only on the start cycle.
  always_comb begin
    case (sel_a)
      SEL_M:   op_a = m_r;
      SEL_ONE: op_a = K'(1);
      SEL_MM:  op_a = mm_r;
      SEL_R2:  op_a = r2_r;
      default: op_a = p;
    endcase
    case (sel_b)
      SEL_M:   op_b = m_r;
      SEL_ONE: op_b = K'(1);
      SEL_MM:  op_b = mm_r;
      SEL_R2:  op_b = r2_r;
      default: op_b = p;
    endcase
  end

  mont_mul_r2 #(.K(K)) u_mont (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (op_a),
    .b     (op_b),
    .n     (n_r),
    .done  (done),
    .p     (p)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next state; each op launches in the same cycle the previous one reports
  // done, so back-to-back ops cost exactly K+2 cycles.
  always_comb begin
    nxt      = state;
    start    = 1'b0;
    sel_a    = SEL_ACC;
    sel_b    = SEL_ACC;
    load_mm  = 1'b0;
    idx_init = 1'b0;
    idx_dec  = 1'b0;
    set_ok   = 1'b0;
    set_bad  = 1'b0;
    case (state)
      IDLE: if (in_valid) nxt = CHECK;
      CHECK: begin
        if (bad) begin
          nxt     = DONE;
          set_bad = 1'b1;
        end else begin
`ifdef RSA_LZ_SKIP_EN
          nxt = SKIP;
`else
          nxt      = TO_MONT;
          start    = 1'b1;
          sel_a    = SEL_M;
          sel_b    = SEL_R2;
          idx_init = 1'b1;
`endif
        end
      end
`ifdef RSA_LZ_SKIP_EN
      SKIP: begin
        nxt      = TO_MONT;
        start    = 1'b1;
        sel_a    = SEL_M;
        sel_b    = SEL_R2;
        idx_init = 1'b1;
      end
`endif
      TO_MONT: if (done) begin
        nxt     = INIT_ACC;
        start   = 1'b1;
        sel_a   = SEL_ONE;
        sel_b   = SEL_R2;
        load_mm = 1'b1;
      end
      INIT_ACC: if (done) begin
        start = 1'b1;
`ifdef RSA_LZ_SKIP_EN
        // A = R here, so squaring at the top bit is a no-op: go straight
        // to the multiply, or to FROM_MONT when there are no set bits.
        if (e_r == '0) begin
          nxt   = FROM_MONT;
          sel_b = SEL_ONE;
        end else begin
          nxt   = MUL;
          sel_b = SEL_MM;
        end
`else
        nxt = SQR;
`endif
      end
      SQR: if (done) begin
        start = 1'b1;
        if (e_r[idx]) begin
          nxt   = MUL;
          sel_b = SEL_MM;
        end else if (idx == '0) begin
          nxt   = FROM_MONT;
          sel_b = SEL_ONE;
        end else begin
          nxt     = SQR;
          idx_dec = 1'b1;
        end
      end
      MUL: if (done) begin
        start = 1'b1;
        if (idx == '0) begin
          nxt   = FROM_MONT;
          sel_b = SEL_ONE;
        end else begin
          nxt     = SQR;
          idx_dec = 1'b1;
        end
      end
      FROM_MONT: if (done) begin
        nxt    = DONE;
        set_ok = 1'b1;
      end
      DONE: if (out_valid && out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Request capture, Mm storage and exponent bit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_r  <= '0;
      n_r  <= '0;
      r2_r <= '0;
      e_r  <= '0;
      mm_r <= '0;
      idx  <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        m_r  <= data_in;
        n_r  <= mod_n;
        r2_r <= r2_mod;
        e_r  <= exp_in;
      end
      if (load_mm)       mm_r <= p;
      if (idx_init)      idx  <= idx_start;
      else if (idx_dec)  idx  <= idx - 1'b1;
    end
  end

  // Result registers; out_valid rises one cycle into DONE and only falls
  // on the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      err       <= 1'b0;
    end else begin
      if (set_bad) begin
        data_out <= '0;
        err      <= 1'b1;
      end else if (set_ok) begin
        data_out <= p;
        err      <= 1'b0;
      end
      if (state == DONE && !out_valid)  out_valid <= 1'b1;
      else if (out_valid && out_ready)  out_valid <= 1'b0;
    end
  end

endmodule
